// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: op/state encodings, divide step count and operand helpers shared by the MDU controller
package mdu_ctrl_pkg;
  localparam int MDU_WIDTH = 32;
  localparam int DIV_STEPS = 32;
  localparam logic [1:0] MULT_OP  = 2'b00;
  localparam logic [1:0] MULTU_OP = 2'b01;
  localparam logic [1:0] DIV_OP   = 2'b10;
  localparam logic [1:0] DIVU_OP  = 2'b11;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL     = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;
  function automatic logic is_signed_op(input logic [1:0] op);
    return op == MULT_OP || op == DIV_OP;
  endfunction
  function automatic logic [MDU_WIDTH-1:0] mag(input logic [MDU_WIDTH-1:0] v, input logic sgn);
    return (sgn && v[MDU_WIDTH-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/mdu_ctrl_div_core.sv
// div_core: restoring shift-subtract datapath producing raw unsigned quotient/remainder, one bit per step
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);
  logic [WIDTH-1:0] r_quo, r_rem, r_div;
  logic [WIDTH:0]   w_trial, w_diff;
  logic             w_ge;
  assign w_trial = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_div};
  assign w_ge    = ~w_diff[WIDTH];
  // o_quo/o_rem are the values after the step taken this cycle, so the last step's result is usable at once
  assign o_quo   = {r_quo[WIDTH-2:0], w_ge};
  assign o_rem   = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  // load operands on acceptance, then shift the dividend into the partial remainder one bit per step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
    end else if (i_step) begin
      r_quo <= o_quo;
      r_rem <= o_rem;
    end
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply/divide sequencer for MULT/MULTU/DIV/DIVU; MDU_EARLY_OUT_EN enables zero-operand divide early-out
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int            CW   = $clog2(DIV_STEPS);
  localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);
  state_t             r_state, w_next;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [CW-1:0]      r_cnt;
  logic               w_accept, w_early, w_sgn, w_neg_q, w_neg_r;
  logic [WIDTH-1:0]   w_core_q, w_core_r, w_raw_q, w_raw_r, w_div_hi, w_div_lo;
  logic [2*WIDTH-1:0] w_prod;
  assign w_accept = start && r_state == S_IDLE && !flush;
`ifdef MDU_EARLY_OUT_EN
  // a zero operand makes the divide result trivial; it reuses the one-cycle MUL slot so latency matches multiply
  assign w_early = op[1] && (a == '0 || b == '0);
  assign w_raw_q = (r_state == S_MUL) ? ((r_b == '0) ? '1 : '0) : w_core_q;
  assign w_raw_r = (r_state == S_MUL) ? ((r_b == '0) ? mag(r_a, w_sgn) : '0) : w_core_r;
`else
  assign w_early = 1'b0;
  assign w_raw_q = w_core_q;
  assign w_raw_r = w_core_r;
`endif
  div_core #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_accept && op[1]),
    .i_step     (r_state == S_DIV_RUN),
    .i_dividend (mag(a, is_signed_op(op))),
    .i_divisor  (mag(b, is_signed_op(op))),
    .o_quo      (w_core_q),
    .o_rem      (w_core_r)
  );
  assign w_sgn    = is_signed_op(r_op);
  assign w_prod   = {{WIDTH{w_sgn && r_a[WIDTH-1]}}, r_a} * {{WIDTH{w_sgn && r_b[WIDTH-1]}}, r_b};
  assign w_neg_q  = w_sgn && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
  assign w_neg_r  = w_sgn && r_a[WIDTH-1];
  assign w_div_lo = w_neg_q ? -w_raw_q : w_raw_q;
  assign w_div_hi = w_neg_r ? -w_raw_r : w_raw_r;
  // next-state and handshake outputs; flush overrides everything, including a same-cycle start
  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    busy   = r_state != S_IDLE;
    done   = r_state == S_DONE;
    case (r_state)
      S_IDLE: begin
        stall = start;
        if (w_accept) w_next = (op[1] && !w_early) ? S_DIV_RUN : S_MUL;
      end
      S_MUL: begin
        stall  = 1'b1;
        w_next = S_DONE;
      end
      S_DIV_RUN: begin
        stall = 1'b1;
        if (r_cnt == LAST) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end
  // latch op and operands on the accepting edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= op;
      r_a  <= a;
      r_b  <= b;
    end
  end
  // divide step counter runs 0..LAST while in DIV_RUN and is cleared otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_cnt <= '0;
    else         r_cnt <= (r_state == S_DIV_RUN && w_next == S_DIV_RUN) ? r_cnt + 1'b1 : '0;
  end
  // HI/LO load only on entry to DONE, so they are valid during the done cycle and hold otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) {hi, lo} <= '0;
    else if (w_next == S_DONE) {hi, lo} <= r_op[1] ? {w_div_hi, w_div_lo} : w_prod;
  end
endmodule
